// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with architectural HI/LO registers.
// One result bit per cycle over XLEN cycles, plus a final sign-correction
// cycle, so a start sampled at E0 produces done/HI/LO at E(XLEN+1).
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned WW = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_div_q, op_div_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            dbz_q, dbz_d;
  logic [XLEN-1:0] a_mag_q, a_mag_d;
  logic [XLEN-1:0] b_mag_q, b_mag_d;
  logic [XLEN-1:0] a_raw_q, a_raw_d;
  logic [WW-1:0]   work_q, work_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Datapath helpers
  logic            in_signed;
  logic            in_neg_a;
  logic            in_neg_b;
  logic [XLEN:0]   mul_sum;
  logic [WW-1:0]   mul_next;
  logic [CW-1:0]   div_idx;
  logic            div_bit;
  logic [XLEN+1:0] div_trial;
  logic [WW-1:0]   div_next;
  logic [WW-1:0]   prod_fix;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;

  // Per-cycle step results for both algorithms; FSM picks one
  always_comb begin
    in_signed = ~op[0];
    in_neg_a  = in_signed & a[XLEN-1];
    in_neg_b  = in_signed & b[XLEN-1];

    // Shift-add: multiplier bits consumed LSB first, product bits enter at the top
    mul_sum  = {1'b0, work_q[WW-1:XLEN]} + (b_mag_q[cnt_q] ? {1'b0, a_mag_q} : '0);
    mul_next = {mul_sum, work_q[XLEN-1:1]};

    // Restoring divide: dividend bits fed MSB first; work = {remainder, quotient}
    div_idx   = CW'(XLEN - 1) - cnt_q;
    div_bit   = a_mag_q[div_idx];
    div_trial = {1'b0, work_q[WW-1:XLEN], div_bit} - {2'b00, b_mag_q};
    if (div_trial[XLEN+1]) begin
      // Shifted remainder below divisor, so its dropped MSB is always zero
      div_next = {work_q[WW-2:XLEN], div_bit, work_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_trial[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
    end

    prod_fix = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
    quot     = (sign_a_q ^ sign_b_q) ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    rem      = sign_a_q ? -work_q[WW-1:XLEN] : work_q[WW-1:XLEN];
  end

  // Next-state and register updates for IDLE/RUN/FIN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dbz_d    = dbz_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    a_raw_d  = a_raw_q;
    work_d   = work_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // mthi/mtlo land even alongside start; FIN overwrites them later
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_div_d = op[1];
          sign_a_d = in_neg_a;
          sign_b_d = in_neg_b;
          dbz_d    = op[1] & (b == '0);
          a_mag_d  = in_neg_a ? -a : a;
          b_mag_d  = in_neg_b ? -b : b;
          a_raw_d  = a;
          work_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        work_d = op_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = StFin;
      end
      StFin: begin
        if (!op_div_q) begin
          hi_d = prod_fix[WW-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else if (dbz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and architectural registers; reset discards any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_q    <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      a_raw_q  <= '0;
      work_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dbz_q    <= dbz_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      a_raw_q  <= a_raw_d;
      work_q   <= work_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
